// File: rtl/wand_bus_arbiter.sv
// Round-robin single-owner sequencer for a wired-AND bus with hold limit and idle-high turnaround.
// Optional contention flag is compiled in with the WAND_ARB_CONTENTION_EN macro.
module wand_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] drv,
  output logic [N_REQ-1:0] gnt,
  output logic             bus_out,
  output logic             busy,
  output logic             timeout
`ifdef WAND_ARB_CONTENTION_EN
  ,
  output logic             err_contention
`endif
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD);
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [TW-1:0]    turn_q, turn_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             bus_q, bus_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic             arb_found;
  logic [PW-1:0]    arb_win;
  logic [PW-1:0]    arb_ptr_next;
  logic [PW:0]      arb_idx;

  // Search upward from ptr, wrapping at N_REQ; the first requester found wins.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      arb_idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (arb_idx >= (PW+1)'(N_REQ)) arb_idx = arb_idx - (PW+1)'(N_REQ);
      if (!arb_found && req[arb_idx[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_win   = arb_idx[PW-1:0];
      end
    end
    arb_ptr_next = (arb_win == PW'(N_REQ-1)) ? '0 : arb_win + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    gnt_d     = '0;
    bus_d     = 1'b1;
    timeout_d = 1'b0;
    case (state_q)
      S_GRANT: begin
        gnt_d = gnt_q;
        // Release wins over timeout when both land in the same cycle.
        if (!req[owner_q] || hold_q == HW'(MAX_HOLD-1)) begin
          state_d   = S_TURN;
          gnt_d     = '0;
          turn_d    = '0;
          timeout_d = req[owner_q];
        end else begin
          hold_d = hold_q + 1'b1;
          bus_d  = drv[owner_q];
        end
      end
      S_TURN: begin
        if (turn_q == TW'(TURNAROUND-1)) begin
          state_d = S_IDLE;
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q == S_IDLE || (state_q == S_TURN && turn_q == TW'(TURNAROUND-1))) && arb_found) begin
      state_d        = S_GRANT;
      gnt_d          = '0;
      gnt_d[arb_win] = 1'b1;
      owner_d        = arb_win;
      hold_d         = '0;
      ptr_d          = arb_ptr_next;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      turn_q    <= '0;
      gnt_q     <= '0;
      bus_q     <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
      gnt_q     <= gnt_d;
      bus_q     <= bus_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign bus_out = bus_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

`ifdef WAND_ARB_CONTENTION_EN
  logic err_q, err_d;

  // A non-owner trying to pull low while requesting is flagged; its drive never reaches the bus.
  always_comb err_d = (state_q == S_GRANT) && |(req & ~drv & ~gnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_contention = err_q;
`endif

endmodule
